// File: rtl/core_run_ctrl_pkg.sv
// Shared types and helpers for the core run sequencer.
//   run_state_e : sequencer states
//   ctr_width() : delay counter width for a given maximum delay in cycles
package core_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } run_state_e;

  // Counter holds values 0..max_delay; never narrower than one bit.
  function automatic int ctr_width(input int max_delay);
    return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/core_run_timer.sv
// Loadable down-counter with a zero flag, shared by the RST, SETTLE and
// hart-stagger delays of the run sequencer.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (wins over counting)
//   load_val in   W  value to load
//   zero     out  count is zero (counter idles there until reloaded)
module core_run_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer for one or more RISC-V harts: holds the core in reset, waits a
// settle window, then enables harts with a programmable stagger until every
// hart has halted. Optional watchdog enabled by defining
// CORE_RUN_CTRL_WATCHDOG_EN (otherwise timeout is constant 0).
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   start             1-cycle pulse, begins a run from IDLE or DONE
//   abort             level, forces IDLE (core back in reset)
//   halt_req          per-hart halt request, honoured only in RUN
//   core_reset        active-high reset to the core(s)
//   core_enable       per-hart enable
//   busy              high in RST/SETTLE/RUN
//   done / timeout    sticky completion / watchdog flags
//   cycle_count       RUN cycles elapsed, saturating
//
// state  | meaning
// IDLE   | core held in reset, waiting for start
// RST    | core held in reset for RST_CYCLES
// SETTLE | reset released, harts still disabled
// RUN    | harts enabled by stagger slot until halted
// DONE   | all harts halted or watchdog expired, core left out of reset
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int NUM_HARTS     = 1,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STAGGER       = 0,
  parameter int RUN_CYCLES    = 50,
  parameter int CYC_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_HARTS-1:0] halt_req,
  output logic                 core_reset,
  output logic [NUM_HARTS-1:0] core_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CYC_W-1:0]     cycle_count
);

  localparam int MAX_RS  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_DLY = (MAX_RS > STAGGER) ? MAX_RS : STAGGER;
  localparam int TW      = ctr_width(MAX_DLY);

  localparam logic [TW-1:0] RST_LOAD    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TW-1:0] STAG_LOAD   = TW'((STAGGER > 0) ? STAGGER - 1 : 0);

  localparam logic [NUM_HARTS-1:0] ALL_HARTS = '1;
  localparam logic [NUM_HARTS-1:0] ONE_HART  = NUM_HARTS'(1);
  // With no stagger every hart is released on the first RUN cycle.
  localparam logic [NUM_HARTS-1:0] FIRST_SLOT = (STAGGER == 0) ? ALL_HARTS : ONE_HART;

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [CYC_W-1:0] WD_LIMIT = CYC_W'(RUN_CYCLES);

  run_state_e           state_q, state_d;
  logic [NUM_HARTS-1:0] halted_q, halted_d;
  // Harts whose stagger slot has arrived; always a contiguous run of low bits.
  logic [NUM_HARTS-1:0] released_q, released_d;
  logic [NUM_HARTS-1:0] core_enable_q, core_enable_d;
  logic [CYC_W-1:0]     cycle_count_q, cycle_count_d;
  logic                 core_reset_q, core_reset_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  core_run_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d       = state_q;
    halted_d      = halted_q;
    released_d    = released_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    tmr_load      = 1'b0;
    tmr_val       = STAG_LOAD;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d       = RST;
            tmr_load      = 1'b1;
            tmr_val       = RST_LOAD;
            done_d        = 1'b0;
            timeout_d     = 1'b0;
            cycle_count_d = '0;
            halted_d      = '0;
          end
        end
        RST: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (SETTLE_CYCLES == 0) begin
              state_d    = RUN;
              released_d = FIRST_SLOT;
              tmr_val    = STAG_LOAD;
            end else begin
              state_d = SETTLE;
              tmr_val = SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            state_d    = RUN;
            released_d = FIRST_SLOT;
            tmr_load   = 1'b1;
            tmr_val    = STAG_LOAD;
          end
        end
        RUN: begin
          halted_d = halted_q | halt_req;
          if (cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + 1'b1;
          end
          if (tmr_zero && !released_q[NUM_HARTS-1]) begin
            released_d = (released_q << 1) | ONE_HART;
            tmr_load   = 1'b1;
            tmr_val    = STAG_LOAD;
          end
          // A final halt on the watchdog's last cycle counts as completion.
          if (&halted_d) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (WD_EN && (cycle_count_d >= WD_LIMIT)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    core_reset_d  = (state_d == IDLE) || (state_d == RST);
    busy_d        = (state_d == RST) || (state_d == SETTLE) || (state_d == RUN);
    core_enable_d = (state_d == RUN) ? (released_d & ~halted_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      halted_q      <= '0;
      released_q    <= '0;
      core_enable_q <= '0;
      cycle_count_q <= '0;
      core_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      released_q    <= released_d;
      core_enable_q <= core_enable_d;
      cycle_count_q <= cycle_count_d;
      core_reset_q  <= core_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign core_enable = core_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl (4 harts, stagger 3). Directed vector table, directed
// corner sequences, then random stimulus against a phase/elapsed-time model.
module tb_core_run_ctrl;

  localparam int NH   = 4;
  localparam int ST   = 3;
  localparam int RC   = 4;
  localparam int SC   = 2;
  localparam int RUNC = 50;
  localparam int CW   = 32;

  localparam int P_IDLE = 0, P_RST = 1, P_SETTLE = 2, P_RUN = 3, P_DONE = 4;

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [39:0] RESET_OUTS = {1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NH-1:0] halt_req = '0;
  logic          core_reset, busy, done, timeout;
  logic [NH-1:0] core_enable;
  logic [CW-1:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: current phase, cycles spent in RST/SETTLE, cycles since RUN entry.
  int            m_phase, m_t, m_r;
  logic [NH-1:0] m_halted;
  logic          m_done, m_to;
  longint        m_cnt;

  typedef struct {
    logic       st;
    logic [3:0] hr;
    logic       rs;
    logic [3:0] en;
    logic       bs;
    logic       dn;
    int         cnt;
  } vec_t;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .NUM_HARTS(NH), .RST_CYCLES(RC), .SETTLE_CYCLES(SC),
    .STAGGER(ST), .RUN_CYCLES(RUNC), .CYC_W(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .halt_req(halt_req),
    .core_reset(core_reset), .core_enable(core_enable), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_t = 0; m_r = 0;
    m_halted = '0; m_done = 1'b0; m_to = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic st, input logic ab, input logic [NH-1:0] hr);
    if (ab) begin
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (st) begin
          m_phase = P_RST; m_t = 0;
          m_done = 1'b0; m_to = 1'b0; m_cnt = 0; m_halted = '0;
        end
        P_RST: if (m_t == RC - 1) begin
          if (SC == 0) begin m_phase = P_RUN; m_r = 0; end
          else begin m_phase = P_SETTLE; m_t = 0; end
        end else m_t++;
        P_SETTLE: if (m_t == SC - 1) begin m_phase = P_RUN; m_r = 0; end
                  else m_t++;
        P_RUN: begin
          m_halted = m_halted | hr;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          if (&m_halted) begin m_phase = P_DONE; m_done = 1'b1; end
          else if (WD_EN && m_cnt >= RUNC) begin m_phase = P_DONE; m_to = 1'b1; end
          else m_r++;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [39:0] model_outs();
    logic [NH-1:0] e;
    e = '0;
    for (int i = 0; i < NH; i++)
      e[i] = (m_phase == P_RUN) && (m_r >= i * ST) && !m_halted[i];
    return {(m_phase == P_IDLE || m_phase == P_RST), e,
            (m_phase == P_RST || m_phase == P_SETTLE || m_phase == P_RUN),
            m_done, m_to, m_cnt[31:0]};
  endfunction

  task automatic tick();
    if (!reset) model_step(start, abort, halt_req);
    @(posedge clk); #1;
    check("outputs_vs_model", {core_reset, core_enable, busy, done, timeout, cycle_count},
          model_outs());
  endtask

  task automatic go_to_run();
    start = 1'b1; tick(); start = 1'b0;
    repeat (RC + SC) tick();
    check("run_entry", {core_reset, core_enable, busy}, {1'b0, 4'b0001, 1'b1});
  endtask

  task automatic reset_pulse(input string name);
    #2 reset = 1'b1;
    #1 check(name, {core_reset, core_enable, busy, done, timeout, cycle_count}, RESET_OUTS);
    model_reset();
    #1 reset = 1'b0;
  endtask

  function automatic vec_t mk(logic st, logic [3:0] hr, logic rs, logic [3:0] en,
                              logic bs, logic dn, int cnt);
    vec_t v;
    v.st = st; v.hr = hr; v.rs = rs; v.en = en; v.bs = bs; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {core_reset, core_enable, busy, done, timeout, cycle_count}, RESET_OUTS);
    reset = 1'b0;

    // start, 4 RST cycles, 2 SETTLE cycles, enables at RUN+0/3/6/9, then halts
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 1, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 4'h1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 4'h1, 1, 0, 1));
    tbl.push_back(mk(0, 4'h0, 0, 4'h1, 1, 0, 2));
    tbl.push_back(mk(0, 4'h0, 0, 4'h3, 1, 0, 3));
    tbl.push_back(mk(0, 4'h0, 0, 4'h3, 1, 0, 4));
    tbl.push_back(mk(0, 4'h0, 0, 4'h3, 1, 0, 5));
    tbl.push_back(mk(0, 4'h0, 0, 4'h7, 1, 0, 6));
    tbl.push_back(mk(0, 4'h0, 0, 4'h7, 1, 0, 7));
    tbl.push_back(mk(0, 4'h0, 0, 4'h7, 1, 0, 8));
    tbl.push_back(mk(0, 4'h0, 0, 4'hF, 1, 0, 9));
    tbl.push_back(mk(0, 4'h1, 0, 4'hE, 1, 0, 10));
    tbl.push_back(mk(0, 4'h2, 0, 4'hC, 1, 0, 11));
    tbl.push_back(mk(0, 4'h4, 0, 4'h8, 1, 0, 12));
    tbl.push_back(mk(0, 4'h8, 0, 4'h0, 0, 1, 13));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 0, 1, 13));

    foreach (tbl[k]) begin
      start = tbl[k].st; halt_req = tbl[k].hr;
      tick();
      check($sformatf("vec%0d", k), {core_reset, core_enable, busy, done, cycle_count},
            {tbl[k].rs, tbl[k].en, tbl[k].bs, tbl[k].dn, tbl[k].cnt[31:0]});
    end
    start = 1'b0; halt_req = '0;

    // hart 2 halts before its slot: never enabled, run completes without it
    go_to_run();
    halt_req = 4'b0100; tick(); halt_req = '0;
    repeat (11) begin
      tick();
      check("hart2_gated", core_enable[2], 0);
    end
    halt_req = 4'b0001; tick();
    halt_req = 4'b0010; tick();
    check("done_pending", done, 0);
    halt_req = 4'b1000; tick(); halt_req = '0;
    check("done_wo_hart2", {done, busy, core_enable}, {1'b1, 1'b0, 4'h0});

    // abort out of DONE keeps done
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_keeps_done", {core_reset, busy, done}, 3'b101);

    // watchdog limit with no halts
    go_to_run();
    repeat (RUNC) tick();
    check("watchdog_limit", {busy, done, timeout, cycle_count},
          WD_EN ? {1'b0, 1'b0, 1'b1, 32'd50} : {1'b1, 1'b0, 1'b0, 32'd50});
    abort = 1'b1; tick(); abort = 1'b0;

    // all harts halt on the limit cycle: halt wins
    go_to_run();
    repeat (RUNC - 1) tick();
    halt_req = '1; tick(); halt_req = '0;
    check("halt_at_limit", {busy, done, timeout, cycle_count}, {1'b0, 1'b1, 1'b0, 32'd50});

    // abort on RUN cycle 7, then restart
    go_to_run();
    repeat (7) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_in_run", {core_reset, core_enable, busy}, {1'b1, 4'h0, 1'b0});
    start = 1'b1; tick(); start = 1'b0;
    check("restart_rst", {core_reset, busy, cycle_count}, {1'b1, 1'b1, 32'd0});

    // async reset mid-SETTLE, then start during RUN is ignored
    repeat (RC) tick();
    check("in_settle", {core_reset, busy}, 2'b01);
    reset_pulse("reset_mid_settle");
    go_to_run();
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_run", {core_reset, busy, cycle_count}, {1'b0, 1'b1, 32'd4});

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) reset_pulse("rand_reset");
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 49) == 0);
      for (int h = 0; h < NH; h++) halt_req[h] = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
